execute_stage: RTL and testbench

Three-lane execute stage sitting directly downstream of `issue_queue`: it consumes the per-lane operation, operands, destination tag and ROB index the issue queue dispatches, computes results, and broadcasts them on the common data bus. The CDB feeds both the issue queue's wakeup inputs and the ROB completion ports. Lanes 0 and 1 are single-cycle ALUs. Lane 2 is a long lane that adds a multi-cycle multiplier (compile-time option) with a ready/valid handshake back to the issue queue.

---
 rtl/execute_stage_pkg.sv | 32 +++
 rtl/execute_stage_alu.sv | 45 ++++
 rtl/execute_stage.sv | 201 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg
//   Shared constants for the issue / decode / execute slice: the 4-bit ALU
//   op encoding, datapath width and the physical-tag / ROB-index widths.
//   Also holds the lane-2 FSM state type used when EXEC_MUL_EN is defined.
package execute_stage_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int TAG_W  = 6;
  localparam int ROB_W  = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_PASS = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic {
    L2_IDLE = 1'b0,
    L2_BUSY = 1'b1
  } lane2_state_e;

endpackage

// File: rtl/execute_stage_alu.sv
// exec_alu
//   Purely combinational single-cycle ALU shared by all execute lanes.
//   MUL and the reserved codes 12-15 produce 0; the lane-2 multiplier lives
//   in execute_stage.
// Ports
//   op     in  4  : ALU op (execute_stage_pkg::alu_op_e encoding)
//   rs1    in  32 : first operand
//   rs2    in  32 : second operand / immediate; rs2[4:0] is the shift amount
//   result out 32 : 32-bit wrap-around result
module exec_alu
  import execute_stage_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] rs1_s;
  logic signed [DATA_W-1:0] rs2_s;
  logic        [4:0]        shamt;

  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign shamt = rs2[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = rs1 + rs2;
      OP_SUB:  result = rs1 - rs2;
      OP_AND:  result = rs1 & rs2;
      OP_OR:   result = rs1 | rs2;
      OP_XOR:  result = rs1 ^ rs2;
      OP_SLL:  result = rs1 << shamt;
      OP_SRL:  result = rs1 >> shamt;
      OP_SRA:  result = rs1_s >>> shamt;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (rs1_s < rs2_s)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, (rs1 < rs2)};
      OP_PASS: result = rs2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage
//   Three-lane execute stage fed by issue_queue, broadcasting on the CDB.
//   Lanes 0/1: single-cycle ALU, result registered into the lane's CDB regs.
//   Lane 2: same ALU plus, when the EXEC_MUL_EN macro is defined, a
//   multi-cycle multiplier with an IDLE/BUSY FSM that drops fu_ready[2]
//   while a product is in flight. Without EXEC_MUL_EN, MUL is illegal on
//   every lane (result 0, 1-cycle latency).
// Ports
//   clk, rst (sync, active-high), stall_in (freezes all state)
//   fu_op/fu_rs1/fu_rs2/fu_tags/fu_rob_index/fu_valid [3] : lane inputs
//   fu_ready [3]                                          : lane can accept
//   cdb_tags/cdb_data/cdb_rob_index/cdb_valid [3]         : CDB broadcast
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int LANES   = 3,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic [OP_W-1:0]   fu_op        [LANES],
  input  logic [DATA_W-1:0] fu_rs1       [LANES],
  input  logic [DATA_W-1:0] fu_rs2       [LANES],
  input  logic [TAG_W-1:0]  fu_tags      [LANES],
  input  logic [ROB_W-1:0]  fu_rob_index [LANES],
  input  logic              fu_valid     [LANES],
  output logic              fu_ready     [LANES],
  output logic [TAG_W-1:0]  cdb_tags     [LANES],
  output logic [DATA_W-1:0] cdb_data     [LANES],
  output logic [ROB_W-1:0]  cdb_rob_index[LANES],
  output logic              cdb_valid    [LANES]
);

  if (LANES != 3) begin : g_lanes_chk
    $error("execute_stage: LANES must be 3");
  end
  if (MUL_LAT < 2) begin : g_lat_chk
    $error("execute_stage: MUL_LAT must be at least 2");
  end

  logic              accept      [LANES];
  logic [DATA_W-1:0] alu_res     [LANES];

  logic              cdb_valid_q [LANES];
  logic              cdb_valid_d [LANES];
  logic [TAG_W-1:0]  cdb_tag_q   [LANES];
  logic [TAG_W-1:0]  cdb_tag_d   [LANES];
  logic [ROB_W-1:0]  cdb_rob_q   [LANES];
  logic [ROB_W-1:0]  cdb_rob_d   [LANES];
  logic [DATA_W-1:0] cdb_data_q  [LANES];
  logic [DATA_W-1:0] cdb_data_d  [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_alu
    exec_alu u_alu (
      .op     (fu_op[g]),
      .rs1    (fu_rs1[g]),
      .rs2    (fu_rs2[g]),
      .result (alu_res[g])
    );
  end

`ifdef EXEC_MUL_EN
  localparam int CNT_W = 8;

  lane2_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [TAG_W-1:0]  mul_tag_q, mul_tag_d;
  logic [ROB_W-1:0]  mul_rob_q, mul_rob_d;
  logic [DATA_W-1:0] mul_src_a, mul_src_b, mul_prod;

  // With MUL_LAT == 2 there are no busy cycles: the product is taken straight
  // from the lane inputs on the accepting edge, so one multiplier serves both.
  assign mul_src_a = (MUL_LAT == 2) ? fu_rs1[2] : mul_a_q;
  assign mul_src_b = (MUL_LAT == 2) ? fu_rs2[2] : mul_b_q;
  assign mul_prod  = mul_src_a * mul_src_b;
`endif

  always_comb begin
    for (int l = 0; l < LANES; l++) fu_ready[l] = !stall_in;
`ifdef EXEC_MUL_EN
    if (state_q == L2_BUSY) fu_ready[2] = 1'b0;
`endif
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) accept[l] = fu_valid[l] && fu_ready[l] && !stall_in;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cdb_valid_d[l] = cdb_valid_q[l];
      cdb_tag_d[l]   = cdb_tag_q[l];
      cdb_rob_d[l]   = cdb_rob_q[l];
      cdb_data_d[l]  = cdb_data_q[l];
      if (!stall_in) begin
        cdb_valid_d[l] = accept[l];
        if (accept[l]) begin
          cdb_tag_d[l]  = fu_tags[l];
          cdb_rob_d[l]  = fu_rob_index[l];
          cdb_data_d[l] = alu_res[l];
        end
      end
    end
`ifdef EXEC_MUL_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_tag_d = mul_tag_q;
    mul_rob_d = mul_rob_q;
    if (!stall_in) begin
      case (state_q)
        L2_IDLE: begin
          if (accept[2] && (fu_op[2] == OP_MUL)) begin
            if (MUL_LAT == 2) begin
              cdb_data_d[2] = mul_prod;
            end else begin
              cdb_valid_d[2] = 1'b0;
              cdb_tag_d[2]   = cdb_tag_q[2];
              cdb_rob_d[2]   = cdb_rob_q[2];
              cdb_data_d[2]  = cdb_data_q[2];
              mul_a_d        = fu_rs1[2];
              mul_b_d        = fu_rs2[2];
              mul_tag_d      = fu_tags[2];
              mul_rob_d      = fu_rob_index[2];
              cnt_d          = CNT_W'(MUL_LAT - 2);
              state_d        = L2_BUSY;
            end
          end
        end
        L2_BUSY: begin
          // cnt_q counts busy cycles left including this one; the product is
          // broadcast on the edge closing the last one, MUL_LAT-1 cycles
          // after acceptance, and fu_ready[2] rises alongside cdb_valid[2].
          if (cnt_q == CNT_W'(1)) begin
            cdb_valid_d[2] = 1'b1;
            cdb_tag_d[2]   = mul_tag_q;
            cdb_rob_d[2]   = mul_rob_q;
            cdb_data_d[2]  = mul_prod;
            cnt_d          = '0;
            state_d        = L2_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = L2_IDLE;
      endcase
    end
`endif
  end

  // CDB register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        cdb_valid_q[l] <= 1'b0;
        cdb_tag_q[l]   <= '0;
        cdb_rob_q[l]   <= '0;
        cdb_data_q[l]  <= '0;
      end
`ifdef EXEC_MUL_EN
      state_q <= L2_IDLE;
      cnt_q   <= '0;
`endif
    end else begin
      for (int l = 0; l < LANES; l++) begin
        cdb_valid_q[l] <= cdb_valid_d[l];
        cdb_tag_q[l]   <= cdb_tag_d[l];
        cdb_rob_q[l]   <= cdb_rob_d[l];
        cdb_data_q[l]  <= cdb_data_d[l];
      end
`ifdef EXEC_MUL_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

`ifdef EXEC_MUL_EN
  // Multiplier operand latch; contents are meaningless outside BUSY
  always_ff @(posedge clk) begin
    mul_a_q   <= mul_a_d;
    mul_b_q   <= mul_b_d;
    mul_tag_q <= mul_tag_d;
    mul_rob_q <= mul_rob_d;
  end
`endif

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cdb_valid[l]     = cdb_valid_q[l];
      cdb_tags[l]      = cdb_tag_q[l];
      cdb_rob_index[l] = cdb_rob_q[l];
      cdb_data[l]      = cdb_data_q[l];
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Scoreboard bench for execute_stage. A posedge model process predicts
//   each broadcast (lane, tag, ROB index, result, expected cycle counted in
//   unstalled edges) from the operation rules; a negedge monitor pops and
//   compares, checks frozen outputs during stalls and fu_ready each cycle.
//   Build with +define+EXEC_MUL_EN to exercise the multiplier lane.
module tb_execute_stage;

  localparam int MUL_LAT = 4;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk, rst, stall_in;
  logic [3:0]  fu_op [3];
  logic [31:0] fu_rs1 [3];
  logic [31:0] fu_rs2 [3];
  logic [5:0]  fu_tags [3];
  logic [5:0]  fu_rob_index [3];
  logic        fu_valid [3];
  logic        fu_ready [3];
  logic [5:0]  cdb_tags [3];
  logic [31:0] cdb_data [3];
  logic [5:0]  cdb_rob_index [3];
  logic        cdb_valid [3];

  execute_stage #(.LANES(3), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .fu_op(fu_op), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_tags(fu_tags),
    .fu_rob_index(fu_rob_index), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .cdb_tags(cdb_tags), .cdb_data(cdb_data), .cdb_rob_index(cdb_rob_index),
    .cdb_valid(cdb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   adv = 0;       // count of unstalled, non-reset edges
  int   l2_free = 0;   // lane 2 accepts again once adv reaches this
  int   last_kind = 0; // 0 run, 1 stall, 2 reset
  bit   started = 1'b0;

  logic        snap_v [3];
  logic [5:0]  snap_t [3];
  logic [5:0]  snap_r [3];
  logic [31:0] snap_d [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Reference result from the op definitions, using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input int lane, input logic [3:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint          sa, sbv, p;
    longint unsigned ua, ub;
    int              sh;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sh  = int'(b % 32);
    p   = longint'(64'd1 << sh);
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 32'(ua * longint'(p));
      4'd6:  return 32'(ua / longint'(p));
      4'd7:  return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
      4'd8:  return (sa < sbv) ? 32'd1 : 32'd0;
      4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd10: return b;
      4'd11: return (MUL_EN && lane == 2) ? 32'(ua * ub) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int find_lane(input int l);
    foreach (sbq[i]) if (sbq[i].lane == l) return i;
    return -1;
  endfunction

  // Model: predict accepted work at each edge
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      last_kind = 2;
      sbq.delete();
      l2_free = 0;
    end else if (stall_in) begin
      last_kind = 1;
    end else begin
      bit   l2_rdy;
      exp_t e;
      l2_rdy = (adv >= l2_free);
      adv++;
      last_kind = 0;
      for (int l = 0; l < 3; l++) begin
        if (fu_valid[l] && (l != 2 || l2_rdy)) begin
          e.lane = l;
          e.tag  = fu_tags[l];
          e.rob  = fu_rob_index[l];
          e.data = ref_result(l, fu_op[l], fu_rs1[l], fu_rs2[l]);
          e.due  = adv;
          if (l == 2 && MUL_EN && fu_op[2] == 4'd11) begin
            e.due   = adv + MUL_LAT - 2;
            l2_free = e.due;
          end
          sbq.push_back(e);
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (started) begin
      if (last_kind == 1) begin
        for (int l = 0; l < 3; l++) begin
          chk($sformatf("stall hold valid%0d", l), 32'(cdb_valid[l]), 32'(snap_v[l]));
          chk($sformatf("stall hold tag%0d", l), 32'(cdb_tags[l]), 32'(snap_t[l]));
          chk($sformatf("stall hold rob%0d", l), 32'(cdb_rob_index[l]), 32'(snap_r[l]));
          chk($sformatf("stall hold data%0d", l), cdb_data[l], snap_d[l]);
        end
      end else if (last_kind == 0) begin
        for (int l = 0; l < 3; l++) begin
          int idx;
          idx = find_lane(l);
          if (cdb_valid[l]) begin
            if (idx < 0) begin
              fail_evt($sformatf("unexpected broadcast lane%0d tag=0x%02h data=0x%08h",
                                 l, cdb_tags[l], cdb_data[l]));
            end else begin
              chk($sformatf("lane%0d tag", l), 32'(cdb_tags[l]), 32'(sbq[idx].tag));
              chk($sformatf("lane%0d rob", l), 32'(cdb_rob_index[l]), 32'(sbq[idx].rob));
              chk($sformatf("lane%0d data", l), cdb_data[l], sbq[idx].data);
              chk($sformatf("lane%0d latency", l), 32'(adv), 32'(sbq[idx].due));
              sbq.delete(idx);
            end
          end else if (idx >= 0 && sbq[idx].due <= adv) begin
            fail_evt($sformatf("missing broadcast lane%0d tag=0x%02h due=%0d now=%0d",
                               l, sbq[idx].tag, sbq[idx].due, adv));
            sbq.delete(idx);
          end
        end
      end
      for (int l = 0; l < 3; l++) begin
        chk($sformatf("fu_ready%0d", l), 32'(fu_ready[l]),
            32'(!stall_in && (l != 2 || adv >= l2_free)));
        snap_v[l] = cdb_valid[l];
        snap_t[l] = cdb_tags[l];
        snap_r[l] = cdb_rob_index[l];
        snap_d[l] = cdb_data[l];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int l = 0; l < 3; l++) fu_valid[l] = 1'b0;
  endtask

  task automatic issue(input int l, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag, input logic [5:0] rob);
    fu_valid[l]     = 1'b1;
    fu_op[l]        = op;
    fu_rs1[l]       = a;
    fu_rs2[l]       = b;
    fu_tags[l]      = tag;
    fu_rob_index[l] = rob;
  endtask

  task automatic rand_lane(input int l);
    logic [31:0] corners [6];
    corners[0] = 32'h0;        corners[1] = 32'h1;        corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'd31;
    fu_valid[l]     = ($urandom_range(0, 3) != 0);
    fu_op[l]        = ($urandom_range(0, 4) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
    fu_rs1[l]       = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
    fu_rs2[l]       = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
    fu_tags[l]      = 6'($urandom);
    fu_rob_index[l] = 6'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sw_a [5];
    logic [31:0] sw_b [5];
    logic [3:0]  sw_op [5];
    sw_op[0] = 4'd0; sw_a[0] = 32'hFFFF_FFFF; sw_b[0] = 32'd1;
    sw_op[1] = 4'd1; sw_a[1] = 32'd0;         sw_b[1] = 32'd1;
    sw_op[2] = 4'd7; sw_a[2] = 32'h8000_0000; sw_b[2] = 32'd4;
    sw_op[3] = 4'd8; sw_a[3] = 32'hFFFF_FFFF; sw_b[3] = 32'd1;
    sw_op[4] = 4'd9; sw_a[4] = 32'hFFFF_FFFF; sw_b[4] = 32'd1;

    // Reset with random inputs for two edges
    rst = 1'b1;
    stall_in = 1'b0;
    for (int l = 0; l < 3; l++) rand_lane(l);
    step();
    stall_in = 1'($urandom);
    for (int l = 0; l < 3; l++) rand_lane(l);
    step();
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("reset valid%0d", l), 32'(cdb_valid[l]), 32'd0);
      chk($sformatf("reset tag%0d", l), 32'(cdb_tags[l]), 32'd0);
      chk($sformatf("reset rob%0d", l), 32'(cdb_rob_index[l]), 32'd0);
      chk($sformatf("reset data%0d", l), cdb_data[l], 32'd0);
    end
    rst = 1'b0;
    stall_in = 1'b0;
    clear_all();
    step();

    // ALU sweep on lane 0, back to back
    for (int i = 0; i < 5; i++) begin
      issue(0, sw_op[i], sw_a[i], sw_b[i], 6'h05, 6'h12);
      step();
    end
    clear_all();
    step();

    // Triple issue
    issue(0, 4'd0, 32'd10, 32'd20, 6'h01, 6'h21);
    issue(1, 4'd0, 32'd30, 32'd40, 6'h02, 6'h22);
    issue(2, 4'd0, 32'd50, 32'd60, 6'h03, 6'h23);
    step();
    clear_all();
    step();

    // MUL 7*6 on lane 2
    issue(2, 4'd11, 32'd7, 32'd6, 6'h2A, 6'h3B);
    step();
    clear_all();
    repeat (5) step();

    // Stall during BUSY while lane 0 is broadcasting
    issue(0, 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 6'h11, 6'h01);
    issue(2, 4'd11, 32'h0001_2345, 32'd789, 6'h12, 6'h02);
    step();
    clear_all();
    stall_in = 1'b1;
    issue(0, 4'd0, 32'd1, 32'd1, 6'h13, 6'h03);
    repeat (3) step();
    stall_in = 1'b0;
    clear_all();
    repeat (6) step();

    // Reset one cycle after a MUL accept
    issue(2, 4'd11, 32'd9, 32'd9, 6'h15, 6'h05);
    step();
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();

    // Randomized traffic with stalls and lane-2 protocol violations
    repeat (400) begin
      stall_in = ($urandom_range(0, 9) == 0);
      for (int l = 0; l < 3; l++) rand_lane(l);
      step();
    end
    stall_in = 1'b0;
    clear_all();
    repeat (10) step();
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
